// File: rtl/cv32e40p_obi_pkg.sv
// Shared types and helpers for the cv32e40p OBI memory-side adapter.
//   obi_req_t     : request payload (address, write enable, byte enables, write data)
//   obi_resp_t    : response payload (read data)
//   OBI_DATA_W    : OBI data bus width
//   obi_cnt_width : width of a counter that must hold 0..max_outstanding
package cv32e40p_obi_pkg;

  localparam int unsigned OBI_DATA_W = 32;

  typedef struct packed {
    logic [31:0]           addr;
    logic                  we;
    logic [3:0]            be;
    logic [OBI_DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic [OBI_DATA_W-1:0] rdata;
  } obi_resp_t;

  function automatic int unsigned obi_cnt_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_fifo.sv
// In-order response FIFO with explicit pointer wrap, so any depth works.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears pointers/count)
//   push_i/push_data_i : write one entry (caller guarantees not full)
//   pop_i         : remove head entry (ignored when empty)
//   empty_o, full_o, count_o : occupancy status
//   head_o        : oldest entry (storage is not reset; consumers mask it)
module cv32e40p_obi_resp_fifo
  import cv32e40p_obi_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              push_i,
  input  logic [DATA_W-1:0]                 push_data_i,
  input  logic                              pop_i,
  output logic                              empty_o,
  output logic                              full_o,
  output logic [obi_cnt_width(DEPTH)-1:0]   count_o,
  output logic [DATA_W-1:0]                 head_o
);

  localparam int unsigned CNT_W = obi_cnt_width(DEPTH);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok;

  assign pop_ok = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Explicit wrap compare keeps non-power-of-two depths correct.
    if (push_i) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop_ok) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cv32e40p_obi_mem_adapter.sv
// OBI slave that fronts a single-port synchronous SRAM with fixed read latency.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   req_i/gnt_o, addr_i, we_i, be_i, wdata_i : OBI address phase
//   rvalid_o, rdata_o : OBI response phase (in order)
//   gnt_hold_i, rvalid_hold_i : stall injection for grant and response delivery
//   mem_*             : SRAM port; mem_rdata_i valid MEM_LATENCY cycles after mem_req_o
//   outstanding_o     : granted-but-not-responded transaction count
module cv32e40p_obi_mem_adapter
  import cv32e40p_obi_pkg::*;
#(
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MEM_AW          = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     req_i,
  output logic                                     gnt_o,
  input  logic [31:0]                              addr_i,
  input  logic                                     we_i,
  input  logic [3:0]                               be_i,
  input  logic [31:0]                              wdata_i,
  output logic                                     rvalid_o,
  output logic [31:0]                              rdata_o,
  input  logic                                     gnt_hold_i,
  input  logic                                     rvalid_hold_i,
  output logic                                     mem_req_o,
  output logic                                     mem_we_o,
  output logic [3:0]                               mem_be_o,
  output logic [MEM_AW-1:0]                        mem_addr_o,
  output logic [31:0]                              mem_wdata_o,
  input  logic [31:0]                              mem_rdata_i,
  output logic [obi_cnt_width(MAX_OUTSTANDING)-1:0] outstanding_o
);

  localparam int unsigned CNT_W = obi_cnt_width(MAX_OUTSTANDING);

  obi_req_t               req_s;
  obi_resp_t              push_resp;
  logic [CNT_W-1:0]       outstanding_q, outstanding_d;
  logic [MEM_LATENCY-1:0] pipe_vld_q, pipe_we_q;
  logic                   gnt, rvalid;
  logic                   fifo_push, fifo_empty, fifo_full;
  logic [CNT_W-1:0]       fifo_count;
  logic [OBI_DATA_W-1:0]  fifo_head;
  logic                   unused_addr_bits;

  assign req_s = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};
  assign unused_addr_bits = ^{req_s.addr[31:MEM_AW+2], req_s.addr[1:0]};

  // Capacity uses the registered count only; a response in the same cycle
  // does not free a slot. rst_ni gating keeps grant low while in reset.
  assign gnt   = rst_ni & req_i & ~gnt_hold_i & (outstanding_q < CNT_W'(MAX_OUTSTANDING));
  assign gnt_o = gnt;

  assign mem_req_o   = req_i & gnt;
  assign mem_we_o    = req_s.we;
  assign mem_be_o    = req_s.be;
  assign mem_addr_o  = req_s.addr[MEM_AW+1:2];
  assign mem_wdata_o = req_s.wdata;

  // Valid/we shift register tracks each access until its SRAM data is ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
      pipe_we_q  <= '0;
    end else begin
      pipe_vld_q[0] <= gnt;
      pipe_we_q[0]  <= req_s.we;
      for (int i = 1; i < int'(MEM_LATENCY); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_we_q[i]  <= pipe_we_q[i-1];
      end
    end
  end

  assign fifo_push       = pipe_vld_q[MEM_LATENCY-1];
  assign push_resp.rdata = pipe_we_q[MEM_LATENCY-1] ? '0 : mem_rdata_i;

  cv32e40p_obi_resp_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (OBI_DATA_W)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .push_data_i (push_resp.rdata),
    .pop_i       (rvalid),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  assign rvalid   = ~fifo_empty & ~rvalid_hold_i;
  assign rvalid_o = rvalid;
  // Mask head data so unwritten storage never reaches the bus.
  assign rdata_o  = rvalid ? fifo_head : '0;

  always_comb begin
    case ({gnt, rvalid})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) outstanding_q <= '0;
    else         outstanding_q <= outstanding_d;
  end

  assign outstanding_o = outstanding_q;

  a_no_fifo_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_push && fifo_full));

  a_capacity: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ($countones(pipe_vld_q) + int'(fifo_count)) <= int'(MAX_OUTSTANDING));

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_i && !gnt_o) |=> (req_i && $stable(req_s)));

endmodule

// File: tb/tb_cv32e40p_obi_mem_adapter.sv
module tb_cv32e40p_obi_mem_adapter;

  localparam int unsigned LAT  = 1;
  localparam int unsigned MAXO = 2;
  localparam int unsigned AW   = 16;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [3:0]  be_i = '0;
  logic        gnt_hold_i = 1'b0, rvalid_hold_i = 1'b0;
  logic        gnt_o, rvalid_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic [3:0]  mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [1:0]  outstanding_o;

  cv32e40p_obi_mem_adapter #(.MEM_LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .MEM_AW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .gnt_hold_i(gnt_hold_i), .rvalid_hold_i(rvalid_hold_i), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  // Bench SRAM: byte-writable, one-cycle registered read.
  logic [31:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference memory: word-addressed, byte-masked writes, reads return current word.
  logic [31:0] ref_mem [int];
  function automatic logic [31:0] ref_access(input logic [31:0] a, input logic we,
                                             input logic [3:0] be, input logic [31:0] wd);
    int w;
    logic [31:0] v;
    w = int'(a[AW+1:2]);
    v = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
      ref_mem[w] = v;
      return 32'h0;
    end
    return v;
  endfunction

  // Transaction list and per-run observations.
  logic [31:0] t_addr [64];
  logic        t_we   [64];
  logic [3:0]  t_be   [64];
  logic [31:0] t_wd   [64];
  logic [31:0] exp_d  [64];
  int          g_cyc  [64];
  int          r_cyc  [64];
  logic [31:0] r_data [64];
  logic [AW-1:0] g_maddr [64];
  int          occ    [64];
  int          n_g, n_r, gnt_while_hold, rv_while_hold;
  int          rv_hold_cycles = 0;
  bit          gh_toggle = 0;
  int          idle_pct = 0;

  task automatic set_txn(input int i, input logic [31:0] a, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
    t_addr[i] = a; t_we[i] = we; t_be[i] = be; t_wd[i] = wd;
  endtask

  task automatic calc_expected(input int n);
    for (int i = 0; i < n; i++) exp_d[i] = ref_access(t_addr[i], t_we[i], t_be[i], t_wd[i]);
  endtask

  // Drive n transactions in order, holding each request until granted.
  // Called and returning at posedge+1; cycle 0 is the first driven cycle.
  task automatic run_reqs(input int n);
    int gi, ri, cyc;
    bit pend;
    gi = 0; ri = 0; cyc = 0; pend = 0;
    gnt_while_hold = 0; rv_while_hold = 0;
    while ((gi < n || ri < n) && cyc < 1000) begin
      rvalid_hold_i = (cyc < rv_hold_cycles);
      gnt_hold_i    = gh_toggle ? (cyc % 2 == 1) : 1'b0;
      if (gi < n && (pend || int'($urandom_range(99)) >= idle_pct)) begin
        req_i = 1'b1; addr_i = t_addr[gi]; we_i = t_we[gi]; be_i = t_be[gi]; wdata_i = t_wd[gi];
        pend = 1;
      end else begin
        req_i = 1'b0;
      end
      @(negedge clk);
      if (cyc < 64) occ[cyc] = int'(outstanding_o);
      if (gnt_o && gnt_hold_i) gnt_while_hold++;
      if (rvalid_o && rvalid_hold_i) rv_while_hold++;
      if (gnt_o) begin
        if (gi < 64) begin g_cyc[gi] = cyc; g_maddr[gi] = mem_addr_o; end
        gi++; pend = 0;
      end
      if (rvalid_o) begin
        if (ri < 64) begin r_cyc[ri] = cyc; r_data[ri] = rdata_o; end
        $display("txn %0d: response cycle %0d rdata=%08h", ri, cyc, rdata_o);
        ri++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_i = 1'b0; gnt_hold_i = 1'b0; rvalid_hold_i = 1'b0;
    n_g = gi; n_r = ri;
  endtask

  task automatic test_reset;
    req_i = 1'b1; addr_i = 32'h10; we_i = 1'b0; be_i = 4'hF;
    @(negedge clk); @(negedge clk);
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %0b expected 0", gnt_o); end
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b expected 0", rvalid_o); end
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %08h expected 0", rdata_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req_o); end
    checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding_o); end
    req_i = 1'b0;
    @(posedge clk); #1; rst_ni = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    set_txn(0, 32'h100, 1'b1, 4'hF, 32'hDEADBEEF);
    set_txn(1, 32'h100, 1'b0, 4'hF, 32'h0);
    calc_expected(2);
    run_reqs(2);
    checks++; if (n_g != 2 || n_r != 2) begin errors++; $display("FAIL wr_rd_count: got %0d/%0d expected 2/2", n_g, n_r); end
    checks++; if (g_maddr[0] !== 16'h0040) begin errors++; $display("FAIL wr_mem_addr: got %04h expected 0040", g_maddr[0]); end
    checks++; if (sram[16'h40] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_sram_word: got %08h expected deadbeef", sram[16'h40]); end
    checks++; if (r_cyc[0] != g_cyc[0] + 2) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", r_cyc[0], g_cyc[0] + 2); end
    checks++; if (r_data[0] !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %08h expected 0", r_data[0]); end
    checks++; if (r_cyc[1] != g_cyc[1] + 2) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", r_cyc[1], g_cyc[1] + 2); end
    checks++; if (r_data[1] !== exp_d[1] || r_data[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %08h expected deadbeef", r_data[1]); end
  endtask

  task automatic test_back_to_back;
    set_txn(0, 32'h0, 1'b1, 4'hF, 32'hA0A0_0000);
    set_txn(1, 32'h4, 1'b1, 4'hF, 32'hA4A4_0004);
    set_txn(2, 32'h8, 1'b1, 4'hF, 32'hA8A8_0008);
    calc_expected(3);
    run_reqs(3);
    for (int i = 0; i < 3; i++) set_txn(i, 32'h4 * i, 1'b0, 4'hF, 32'h0);
    calc_expected(3);
    run_reqs(3);
    checks++; if (n_g != 3 || n_r != 3) begin errors++; $display("FAIL b2b_count: got %0d/%0d expected 3/3", n_g, n_r); end
    checks++; if (g_cyc[0] != 0 || g_cyc[1] != 1 || g_cyc[2] != 3) begin errors++; $display("FAIL b2b_grant_cycles: got %0d,%0d,%0d expected 0,1,3", g_cyc[0], g_cyc[1], g_cyc[2]); end
    checks++; if (occ[2] != 2) begin errors++; $display("FAIL b2b_count_full: got %0d expected 2", occ[2]); end
    checks++; if (r_cyc[0] != 2 || r_cyc[1] != 3 || r_cyc[2] != 5) begin errors++; $display("FAIL b2b_resp_cycles: got %0d,%0d,%0d expected 2,3,5", r_cyc[0], r_cyc[1], r_cyc[2]); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (r_data[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %08h expected %08h", i, r_data[i], exp_d[i]); end
    end
  endtask

  task automatic init_pool;
    for (int i = 0; i < 8; i++) set_txn(i, 32'h300 + 4 * i, 1'b1, 4'hF, $urandom);
    calc_expected(8);
    run_reqs(8);
    checks++; if (n_r != 8) begin errors++; $display("FAIL pool_init: got %0d responses expected 8", n_r); end
  endtask

  task automatic test_rvalid_hold;
    for (int i = 0; i < 4; i++) set_txn(i, 32'h300 + 4 * i, 1'b0, 4'hF, 32'h0);
    calc_expected(4);
    rv_hold_cycles = 10;
    run_reqs(4);
    rv_hold_cycles = 0;
    checks++; if (n_g != 4 || n_r != 4) begin errors++; $display("FAIL hold_count: got %0d/%0d expected 4/4", n_g, n_r); end
    checks++; if (g_cyc[0] != 0 || g_cyc[1] != 1 || g_cyc[2] != 11 || g_cyc[3] != 12) begin errors++; $display("FAIL hold_grants: got %0d,%0d,%0d,%0d expected 0,1,11,12", g_cyc[0], g_cyc[1], g_cyc[2], g_cyc[3]); end
    checks++; if (occ[9] != 2) begin errors++; $display("FAIL hold_outstanding: got %0d expected 2", occ[9]); end
    checks++; if (rv_while_hold != 0) begin errors++; $display("FAIL hold_rvalid_leak: got %0d expected 0", rv_while_hold); end
    checks++; if (r_cyc[0] != 10 || r_cyc[1] != 11) begin errors++; $display("FAIL hold_release: got %0d,%0d expected 10,11", r_cyc[0], r_cyc[1]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (r_data[i] !== exp_d[i]) begin errors++; $display("FAIL hold_data[%0d]: got %08h expected %08h", i, r_data[i], exp_d[i]); end
    end
  endtask

  task automatic test_gnt_hold_random;
    int bad_lat;
    for (int i = 0; i < 30; i++)
      set_txn(i, 32'h300 + 4 * $urandom_range(7) + $urandom_range(3), 1'($urandom_range(1)),
              4'($urandom_range(15)), $urandom);
    calc_expected(30);
    gh_toggle = 1; idle_pct = 30;
    run_reqs(30);
    gh_toggle = 0; idle_pct = 0;
    checks++; if (n_g != 30 || n_r != 30) begin errors++; $display("FAIL rand_count: got %0d/%0d expected 30/30", n_g, n_r); end
    checks++; if (gnt_while_hold != 0) begin errors++; $display("FAIL rand_gnt_during_hold: got %0d expected 0", gnt_while_hold); end
    bad_lat = 0;
    for (int i = 0; i < 30; i++) begin
      if (r_cyc[i] < g_cyc[i] + 2) bad_lat++;
      checks++; if (r_data[i] !== exp_d[i]) begin errors++; $display("FAIL rand_data[%0d]: got %08h expected %08h", i, r_data[i], exp_d[i]); end
    end
    checks++; if (bad_lat != 0) begin errors++; $display("FAIL rand_latency: got %0d early responses expected 0", bad_lat); end
  endtask

  task automatic test_byte_write;
    set_txn(0, 32'h200, 1'b1, 4'hF, 32'h11223344);
    set_txn(1, 32'h200, 1'b1, 4'b0010, 32'h0000AB00);
    set_txn(2, 32'h200, 1'b0, 4'hF, 32'h0);
    calc_expected(3);
    run_reqs(3);
    checks++; if (n_r != 3) begin errors++; $display("FAIL byte_count: got %0d expected 3", n_r); end
    checks++; if (r_data[2] !== 32'h1122AB44) begin errors++; $display("FAIL byte_merge: got %08h expected 1122ab44", r_data[2]); end
  endtask

  task automatic test_reset_midop;
    int stale;
    req_i = 1'b1; addr_i = 32'h300; we_i = 1'b0; be_i = 4'hF;
    @(negedge clk); @(posedge clk); #1;
    addr_i = 32'h304;
    @(negedge clk); @(posedge clk); #1;
    req_i = 1'b0; rvalid_hold_i = 1'b1;
    @(negedge clk);
    checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL rst_inflight: got %0d expected 2", outstanding_o); end
    #2; rst_ni = 1'b0; req_i = 1'b1; rvalid_hold_i = 1'b0;
    #1;
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL rst_mid_gnt: got %0b expected 0", gnt_o); end
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid: got %0b expected 0", rvalid_o); end
    checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL rst_mid_outstanding: got %0d expected 0", outstanding_o); end
    req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_ni = 1'b1;
    stale = 0;
    repeat (3) begin @(negedge clk); if (rvalid_o) stale++; @(posedge clk); #1; end
    set_txn(0, 32'h0, 1'b0, 4'hF, 32'h0);
    calc_expected(1);
    run_reqs(1);
    repeat (3) begin @(negedge clk); if (rvalid_o) stale++; @(posedge clk); #1; end
    checks++; if (stale != 0) begin errors++; $display("FAIL rst_stale_rvalid: got %0d expected 0", stale); end
    checks++; if (n_g != 1 || n_r != 1) begin errors++; $display("FAIL rst_fresh_count: got %0d/%0d expected 1/1", n_g, n_r); end
    checks++; if (g_cyc[0] != 0 || r_cyc[0] != 2) begin errors++; $display("FAIL rst_fresh_latency: got %0d->%0d expected 0->2", g_cyc[0], r_cyc[0]); end
    checks++; if (r_data[0] !== exp_d[0]) begin errors++; $display("FAIL rst_fresh_data: got %08h expected %08h", r_data[0], exp_d[0]); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    init_pool;
    test_rvalid_hold;
    test_gnt_hold_random;
    test_byte_write;
    test_reset_midop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
